// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter slice.
//   - ALU opcode constants (ALUControl encodings, including the two unused codes)
//   - FSM state encodings (2-bit, legacy-compatible constants)
//   - Registered response bundle type and an opcode-legality helper
package alu_share_arbiter_pkg;

  typedef logic [2:0] alu_op_t;
  typedef logic [1:0] arb_state_t;

  localparam alu_op_t OP_AND      = 3'b000;
  localparam alu_op_t OP_OR       = 3'b001;
  localparam alu_op_t OP_ADD      = 3'b010;
  localparam alu_op_t OP_NOTUSED1 = 3'b011;
  localparam alu_op_t OP_SUB      = 3'b100;
  localparam alu_op_t OP_MULT     = 3'b101;
  localparam alu_op_t OP_SLT      = 3'b110;
  localparam alu_op_t OP_NOTUSED2 = 3'b111;

  localparam arb_state_t ST_IDLE = 2'b00;
  localparam arb_state_t ST_EXEC = 2'b01;
  localparam arb_state_t ST_RESP = 2'b10;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        err;
  } alu_rsp_t;

  function automatic logic is_unused_op(input alu_op_t op);
    return (op == OP_NOTUSED1) || (op == OP_NOTUSED2);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bus between NREQ requesters and the ALU share arbiter.
//   req_valid/req_ready  per-requester request handshake (ready is one-hot)
//   req_op/req_a/req_b   packed per-requester operation and operands
//   rsp_valid/rsp_ready  per-requester response handshake (valid is one-hot)
//   rsp_result/zero/err  response of the owning operation
//   busy                 arbiter is not idle
// master: requester side, slave: arbiter side.
interface alu_share_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [3*NREQ-1:0]    req_op;
  logic [32*NREQ-1:0]   req_a;
  logic [32*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [31:0]          rsp_result;
  logic                 rsp_zero;
  logic                 rsp_err;
  logic                 busy;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, busy
  );
endinterface

// File: rtl/alu_share_arbiter_alu.sv
// ALU_32_bits: combinational 32-bit ALU.
//   SrcA, SrcB   operands
//   ALUControl   opcode (AND, OR, ADD, SUB, MULT low word, SLT unsigned)
//   ALUResult    32-bit result (overflow and product high word discarded)
//   Zero         ALUResult == 0
module ALU_32_bits
  import alu_share_arbiter_pkg::*;
(
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  alu_op_t     ALUControl,
  output logic [31:0] ALUResult,
  output logic        Zero
);

  always_comb begin
    ALUResult = '0;
    case (ALUControl)
      OP_AND:  ALUResult = SrcA & SrcB;
      OP_OR:   ALUResult = SrcA | SrcB;
      OP_ADD:  ALUResult = SrcA + SrcB;
      OP_SUB:  ALUResult = SrcA - SrcB;
      OP_MULT: ALUResult = SrcA * SrcB;
      OP_SLT:  ALUResult = {31'b0, (SrcA < SrcB)};
      default: ALUResult = '0;
    endcase
  end

  assign Zero = (ALUResult == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU_32_bits between NREQ requesters.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of alu_share_arbiter_if (request/response handshakes,
//          response data and busy)
// Round-robin grant in IDLE, operands registered on accept, one EXEC cycle,
// then the result is held in RESP until the owner takes it.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_share_arbiter_if.slave   bus
);

  arb_state_t       r_state;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_owner;
  alu_op_t          r_op;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [NREQ-1:0]  r_rsp_valid;
  alu_rsp_t         r_rsp;

  logic [IDW-1:0]   w_pick;
  logic [NREQ-1:0]  w_grant;
  logic             w_accept;
  logic [31:0]      w_alu_result;
  logic             w_alu_zero;
  logic             w_op_err;

  // First valid requester at or after ptr, wrapping modulo NREQ. Scanning
  // the offsets downward lets the smallest offset win by overwriting.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                             input logic [IDW-1:0]  ptr);
    logic [IDW-1:0] pick;
    int unsigned    idx;
    pick = '0;
    for (int unsigned k = NREQ; k > 0; k--) begin
      idx = (32'(ptr) + k - 1) % NREQ;
      if (valid[idx]) pick = IDW'(idx);
    end
    return pick;
  endfunction

  always_comb begin
    w_pick  = rr_pick(bus.req_valid, r_rr_ptr);
    w_grant = '0;
    // Gated by rst_n so ready is low while reset is held, even with valids up.
    if (rst_n && (r_state == ST_IDLE) && (|bus.req_valid))
      w_grant = NREQ'(1) << w_pick;
    w_accept = |(bus.req_valid & w_grant);
  end

  ALU_32_bits u_alu (
    .SrcA       (r_a),
    .SrcB       (r_b),
    .ALUControl (r_op),
    .ALUResult  (w_alu_result),
    .Zero       (w_alu_zero)
  );

  assign w_op_err = is_unused_op(r_op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rsp_valid <= '0;
      r_rsp       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_owner <= w_pick;
            r_op    <= bus.req_op[3*w_pick +: 3];
            r_a     <= bus.req_a[32*w_pick +: 32];
            r_b     <= bus.req_b[32*w_pick +: 32];
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp.result <= w_op_err ? '0   : w_alu_result;
          r_rsp.zero   <= w_op_err ? 1'b1 : w_alu_zero;
          r_rsp.err    <= w_op_err;
          r_rsp_valid  <= NREQ'(1) << r_owner;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready[r_owner]) begin
            r_rsp_valid <= '0;
            r_rr_ptr    <= (r_owner == IDW'(NREQ - 1)) ? '0 : r_owner + IDW'(1);
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = w_grant;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_result = r_rsp.result;
  assign bus.rsp_zero   = r_rsp.zero;
  assign bus.rsp_err    = r_rsp.err;
  assign bus.busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter (NREQ=2): directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// transaction-level model of the arbiter.
module tb_alu_share_arbiter;

  localparam int N = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.NREQ(N)) bus ();

  alu_share_arbiter #(.NREQ(N), .IDW(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  // Reference ALU straight from the opcode table.
  function automatic void ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic z, output logic e);
    longint unsigned p;
    r = 32'd0;
    e = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a + b;
      3'd4: r = a - b;
      3'd5: begin p = longint'(a) * longint'(b); r = p[31:0]; end
      3'd6: r = (a < b) ? 32'd1 : 32'd0;
      default: e = 1'b1;
    endcase
    z = (r == 32'd0);
  endfunction

  // ---------------- transaction-level model + per-cycle compare ------------
  bit          m_open = 1'b0;   // an operation is owned by a requester
  bit          m_done = 1'b0;   // its result has been produced
  int          m_owner = 0;
  int          m_rr = 0;
  logic [2:0]  m_op = '0;
  logic [31:0] m_a = '0, m_b = '0, m_res = '0;
  logic        m_zero = 1'b0, m_err = 1'b0;
  int          m_completed = 0;

  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rv;
    int           pick;
    if (!rst_n) begin
      m_open = 0; m_done = 0; m_owner = 0; m_rr = 0;
      m_res = '0; m_zero = 1'b0; m_err = 1'b0;
    end
    exp_ready = '0;
    pick = -1;
    if (rst_n && !m_open)
      for (int k = 0; k < N; k++)
        if (pick < 0 && bus.req_valid[(m_rr + k) % N]) pick = (m_rr + k) % N;
    if (pick >= 0) exp_ready[pick] = 1'b1;
    exp_rv = '0;
    if (m_open && m_done) exp_rv[m_owner] = 1'b1;

    chk("req_ready",  32'(bus.req_ready),  32'(exp_ready));
    chk("rsp_valid",  32'(bus.rsp_valid),  32'(exp_rv));
    chk("rsp_result", bus.rsp_result,      m_res);
    chk("rsp_zero",   32'(bus.rsp_zero),   32'(m_zero));
    chk("rsp_err",    32'(bus.rsp_err),    32'(m_err));
    chk("busy",       32'(bus.busy),       32'(m_open));

    if (rst_n) begin
      if (!m_open) begin
        if (pick >= 0) begin
          m_open = 1; m_done = 0; m_owner = pick;
          m_op = bus.req_op[3*pick +: 3];
          m_a  = bus.req_a[32*pick +: 32];
          m_b  = bus.req_b[32*pick +: 32];
        end
      end else if (!m_done) begin
        ref_alu(m_op, m_a, m_b, m_res, m_zero, m_err);
        m_done = 1;
      end else if (bus.rsp_ready[m_owner]) begin
        m_open = 0;
        m_rr = (m_owner + 1) % N;
        m_completed++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req_op[3*i +: 3]  = op;
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
    bus.req_valid[i]      = 1'b1;
  endtask

  // Waits for requester i's handshake; returns the cycle count seen at the
  // negedge just before the accepting edge, then drops valid after that edge.
  task automatic wait_accept(input int i, output int hs_cyc);
    bit got;
    got = 0;
    hs_cyc = -1;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (bus.req_valid[i] && bus.req_ready[i]) begin got = 1; hs_cyc = cyc; end
    end
    chk($sformatf("accept_req%0d", i), 32'(got), 32'd1);
    tick();
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int i, input logic [31:0] er, input logic ez, input logic ee,
                          input string nm, output int rv_cyc);
    bit got;
    got = 0;
    rv_cyc = -1;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (bus.rsp_valid[i]) got = 1;
    end
    chk({nm, "_rsp_seen"}, 32'(got), 32'd1);
    rv_cyc = cyc;
    chk({nm, "_result"}, bus.rsp_result,      er);
    chk({nm, "_zero"},   32'(bus.rsp_zero),   32'(ez));
    chk({nm, "_err"},    32'(bus.rsp_err),    32'(ee));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic z, e;
    int h0, h1, rv, rel;
    logic [N-1:0] hs;

    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '1;

    // Pin the reference model with hand-computed values.
    ref_alu(3'b010, 32'd5, 32'd7, r, z, e);
    chk("model_add", r, 32'd12);
    ref_alu(3'b101, 32'h0001_0000, 32'h0001_0000, r, z, e);
    chk("model_mult_zero", 32'(z), 32'd1);
    ref_alu(3'b110, 32'd2, 32'hFFFF_FFFF, r, z, e);
    chk("model_slt", r, 32'd1);
    ref_alu(3'b111, 32'd3, 32'd4, r, z, e);
    chk("model_illegal_err", 32'(e), 32'd1);
    ref_alu(3'b100, 32'd9, 32'd9, r, z, e);
    chk("model_sub_zero", 32'(z), 32'd1);

    // Both requesters valid across reset exit.
    set_req(0, 3'b010, 32'd5, 32'd7);
    set_req(1, 3'b001, 32'h0000_00F0, 32'h0000_000F);
    @(negedge clk);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset_busy",      32'(bus.busy),      32'd0);
    tick();
    rst_n = 1'b1;
    rel = cyc;

    // Single ADD latency and contention order.
    wait_accept(0, h0);
    chk("first_grant_immediate", 32'(h0 - rel), 32'd0);
    wait_rsp(0, 32'd12, 1'b0, 1'b0, "add", rv);
    chk("add_latency", 32'(rv - h0), 32'd2);
    wait_accept(1, h1);
    chk("next_accept_gap", 32'(h1 - h0), 32'd3);
    wait_rsp(1, 32'h0000_00FF, 1'b0, 1'b0, "or", rv);

    // Second simultaneous pair: rr pointer wrapped to 0.
    tick();
    set_req(0, 3'b110, 32'd2, 32'hFFFF_FFFF);
    set_req(1, 3'b101, 32'h0001_0000, 32'h0001_0000);
    wait_accept(0, h0);
    wait_rsp(0, 32'd1, 1'b0, 1'b0, "slt", rv);
    wait_accept(1, h1);
    chk("pair_order", 32'(h1 > h0), 32'd1);
    wait_rsp(1, 32'd0, 1'b1, 1'b0, "mult", rv);

    // Backpressure on requester 1; rsp_ready[0] must be ignored.
    tick();
    bus.rsp_ready = 2'b00;
    set_req(1, 3'b100, 32'd9, 32'd9);
    wait_accept(1, h1);
    set_req(0, 3'b010, 32'd1, 32'd2);
    bus.rsp_ready[0] = 1'b1;
    wait_rsp(1, 32'd0, 1'b1, 1'b0, "sub", rv);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(bus.rsp_valid),  32'd2);
      chk("bp_result",    bus.rsp_result,      32'd0);
      chk("bp_zero",      32'(bus.rsp_zero),   32'd1);
      chk("bp_req_ready", 32'(bus.req_ready),  32'd0);
    end
    tick();
    bus.rsp_ready = 2'b11;
    wait_accept(0, h0);
    wait_rsp(0, 32'd3, 1'b0, 1'b0, "bp_follow", rv);

    // Unused opcode, then a legal op clears err.
    tick();
    set_req(0, 3'b111, 32'd3, 32'd4);
    wait_accept(0, h0);
    wait_rsp(0, 32'd0, 1'b1, 1'b1, "illegal", rv);
    tick();
    set_req(1, 3'b000, 32'h0000_F0F0, 32'h0000_0FF0);
    wait_accept(1, h1);
    wait_rsp(1, 32'h0000_00F0, 1'b0, 1'b0, "and_after_illegal", rv);

    // Reset in EXEC with rr pointing at requester 1: next grant goes to 0.
    tick();
    set_req(0, 3'b001, 32'd1, 32'd2);
    wait_accept(0, h0);
    wait_rsp(0, 32'd3, 1'b0, 1'b0, "or_pre_reset", rv);
    tick();
    set_req(1, 3'b010, 32'd10, 32'd20);
    wait_accept(1, h1);
    rst_n = 1'b0;
    set_req(0, 3'b010, 32'd100, 32'd1);
    set_req(1, 3'b010, 32'd200, 32'd2);
    #1;
    chk("rst_req_ready",  32'(bus.req_ready),  32'd0);
    chk("rst_rsp_valid",  32'(bus.rsp_valid),  32'd0);
    chk("rst_result",     bus.rsp_result,      32'd0);
    chk("rst_zero",       32'(bus.rsp_zero),   32'd0);
    chk("rst_err",        32'(bus.rsp_err),    32'd0);
    chk("rst_busy",       32'(bus.busy),       32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    rel = cyc;
    wait_accept(0, h0);
    chk("post_reset_grant0", 32'(h0 - rel), 32'd0);
    wait_rsp(0, 32'd101, 1'b0, 1'b0, "post_reset0", rv);
    wait_accept(1, h1);
    wait_rsp(1, 32'd202, 1'b0, 1'b0, "post_reset1", rv);

    // Randomized traffic; operands held stable while waiting for a grant.
    m_completed = 0;
    for (int it = 0; it < 1500; it++) begin
      @(negedge clk);
      hs = bus.req_valid & bus.req_ready;
      tick();
      for (int i = 0; i < N; i++) begin
        if (hs[i]) bus.req_valid[i] = 1'b0;
        else if (!bus.req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom(),
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom());
        bus.rsp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      if (it == 700) begin
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
      end
    end
    chk("random_progress", 32'(m_completed > 100), 32'd1);

    tick();
    tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
